// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial unsigned adder (LSB first, one bit per clock)
// with valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic carry_q, carry_d, c_q, c_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic p, g, s, c_next, last;
   always_comb begin
      state_d = state_q;
      a_d = a_q;
      b_d = b_q;
      sum_d = sum_q;
      carry_d = carry_q;
      c_d = c_q;
      cnt_d = cnt_q;
      p = a_q[0] ^ b_q[0];
      g = a_q[0] & b_q[0];
      s = p ^ c_q;
      c_next = g | (p & c_q);
      last = cnt_q == CW'(WIDTH - 1);
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = RUN;
            a_d = A;
            b_d = B;
            c_d = 1'b0;
            cnt_d = '0;
         end
         RUN: begin
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            sum_d = {s, sum_q[WIDTH-1:1]};
            c_d = c_next;
            // counter holds on the final bit so it never wraps
            cnt_d = last ? cnt_q : cnt_q + CW'(1);
            if (last) begin
               state_d = DONE;
               carry_d = c_next;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q <= '0;
         b_q <= '0;
         sum_q <= '0;
         carry_q <= 1'b0;
         c_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         b_q <= b_d;
         sum_q <= sum_d;
         carry_q <= carry_d;
         c_q <= c_d;
         cnt_q <= cnt_d;
      end
   end
   assign in_ready = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign busy = state_q != IDLE;
   assign Sum = sum_q;
   assign Carry = carry_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: random and directed stimulus with a queue scoreboard
// and a cycle-timing reference model of the handshake.
module tb_serial_adder_ctrl;
   localparam int W = 8;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [W-1:0] A = '0, B = '0;
   logic in_ready, out_valid, Carry, busy;
   logic [W-1:0] Sum;
   int checks = 0, failures = 0;
   logic [W:0] exp_q[$];
   int m_left = -1;
   int rst_cnt = 0, mon_rst = 0;
   logic [W:0] cur = '0, last = '0;
   bit seen = 1'b0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
      .Sum(Sum), .Carry(Carry), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   // m_left: -1 idle, >0 cycles until the result appears, 0 result presented
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = -1;
         exp_q.delete();
         rst_cnt++;
      end else if (m_left == -1) begin
         if (in_valid) begin
            exp_q.push_back({1'b0, A} + {1'b0, B});
            m_left = W;
         end
      end else if (m_left > 0) m_left--;
      else if (out_ready) m_left = -1;
   end

   always @(negedge clk) begin
      if (rst_cnt != mon_rst) begin
         mon_rst = rst_cnt;
         seen = 1'b0;
         last = '0;
      end
      chk("in_ready", {8'b0, in_ready}, {8'b0, m_left == -1});
      chk("out_valid", {8'b0, out_valid}, {8'b0, m_left == 0});
      chk("busy", {8'b0, busy}, {8'b0, m_left != -1});
      if (out_valid) begin
         if (!seen) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL result_unexpected actual=%h required=none", {Carry, Sum});
               cur = {Carry, Sum};
            end else begin
               cur = exp_q.pop_front();
               chk("result", {Carry, Sum}, cur);
            end
            seen = 1'b1;
            last = cur;
         end else chk("result_hold", {Carry, Sum}, cur);
      end else begin
         seen = 1'b0;
         if (m_left == -1) chk("idle_keep", {Carry, Sum}, last);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!in_ready && t < 200) begin
         tick();
         t++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL wait_ready actual=timeout required=in_ready");
      end
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      wait_ready();
      in_valid = 1'b1;
      A = a;
      B = b;
      tick();
      in_valid = 1'b0;
      A = W'($urandom);
      B = W'($urandom);
   endtask

   task automatic drain();
      int t = 0;
      while ((m_left != -1 || exp_q.size() != 0) && t < 200) begin
         tick();
         t++;
      end
      tick();
   endtask

   initial begin
      tick(3);
      rst = 1'b0;
      tick();
      out_ready = 1'b1;
      send(8'h03, 8'h05);
      drain();
      send(8'hFF, 8'h01);
      drain();
      send(8'hFF, 8'hFF);
      drain();
      send(8'hAA, 8'h55);
      drain();
      send(8'h00, 8'h00);
      drain();
      out_ready = 1'b0;
      send(8'h5A, 8'hC3);
      for (int t = 0; t < 50 && !out_valid; t++) tick();
      repeat (5) begin
         in_valid = 1'($urandom);
         A = W'($urandom);
         B = W'($urandom);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      in_valid = 1'b1;
      repeat (40) begin
         A = W'($urandom);
         B = W'($urandom);
         tick();
      end
      in_valid = 1'b0;
      drain();
      send(8'h37, 8'h4C);
      tick(4);
      #1 rst = 1'b1;
      #1;
      chk("rst_sum", {1'b0, Sum}, 9'h000);
      chk("rst_carry", {8'b0, Carry}, 9'h000);
      chk("rst_out_valid", {8'b0, out_valid}, 9'h000);
      chk("rst_busy", {8'b0, busy}, 9'h000);
      chk("rst_in_ready", {8'b0, in_ready}, 9'h001);
      rst = 1'b0;
      tick();
      send(8'h10, 8'h20);
      drain();
      in_valid = 1'b1;
      A = 8'h80;
      B = 8'h80;
      wait_ready();
      tick();
      A = 8'h01;
      B = 8'h01;
      wait_ready();
      tick();
      in_valid = 1'b0;
      drain();
      repeat (300) begin
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 2) != 0;
         A = W'($urandom);
         B = W'($urandom);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      chk("queue_empty", 9'(exp_q.size()), 9'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
